// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle RV32I control FSM (master) and the datapath (slave).
interface multicycle_ctrl_fsm_if;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic [2:0] ImmSrc_o;
  logic [1:0] ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALUOp_o;
  logic [1:0] ResultSrc_o;
  logic       AdrSrc_o;
  logic       IRWrite_o;
  logic       PCWrite_o;
  logic       RegWrite_o;
  logic       MemWrite_o;
  logic       illegal_o;
  logic [3:0] state_o;

  modport master (
    input  op_i, funct3_i, zero_i, mem_ready_i,
    output ImmSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o, AdrSrc_o,
           IRWrite_o, PCWrite_o, RegWrite_o, MemWrite_o, illegal_o, state_o
  );

  modport slave (
    output op_i, funct3_i, zero_i, mem_ready_i,
    input  ImmSrc_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o, AdrSrc_o,
           IRWrite_o, PCWrite_o, RegWrite_o, MemWrite_o, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute and drives datapath selects.
// Optional macro PERF_CNT_EN adds cycle and retired-instruction counters of DATA_WIDTH bits.
module multicycle_ctrl_fsm
`ifdef PERF_CNT_EN
  #(parameter int DATA_WIDTH = 32)
`endif
(
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
`ifdef PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] cycle_cnt_o,
  output logic [DATA_WIDTH-1:0] instret_cnt_o
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR  = 4'd6,  S_EXECI  = 4'd7,
    S_ALUWB   = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_LUI     = 4'd12, S_AUIPC  = 4'd13, S_ILLEGAL = 4'd14
  } state_t;

  state_t     state_q, state_d;
  logic       phase_q, phase_d;
  logic       illegal_q;
  logic [2:0] imm_s;
  logic [1:0] srca_s, srcb_s, aluop_s, res_s;
  logic       adr_s, irw_s, pcw_s, rw_s, mw_s;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      7'b0100011:             imm_sel = 3'b001;
      7'b1100011:             imm_sel = 3'b010;
      7'b0110111, 7'b0010111: imm_sel = 3'b011;
      7'b1101111:             imm_sel = 3'b100;
      default:                imm_sel = 3'b000;
    endcase
  endfunction

  // Next-state and control decode from the current state.
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    imm_s   = imm_sel(bus.op_i);
    srca_s  = 2'b00;
    srcb_s  = 2'b00;
    aluop_s = 2'b00;
    res_s   = 2'b00;
    adr_s   = 1'b0;
    irw_s   = 1'b0;
    pcw_s   = 1'b0;
    rw_s    = 1'b0;
    mw_s    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imm_s  = 3'b000;
        srcb_s = 2'b10;
        res_s  = 2'b10;
        if (bus.mem_ready_i) begin
          irw_s   = 1'b1;
          pcw_s   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        srca_s = 2'b01;
        srcb_s = 2'b01;
        case (bus.op_i)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BRANCH;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALR;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_AUIPC;
          default:                state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        srca_s = 2'b10;
        srcb_s = 2'b01;
        if (bus.op_i[5]) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        adr_s = 1'b1;
        if (bus.mem_ready_i) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB: begin
        res_s   = 2'b01;
        rw_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        adr_s = 1'b1;
        mw_s  = 1'b1;
        if (bus.mem_ready_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_EXECR, S_EXECI: begin
        srca_s  = 2'b10;
        srcb_s  = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        aluop_s = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rw_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca_s  = 2'b10;
        aluop_s = 2'b01;
        case (bus.funct3_i)
          3'b000: begin
            pcw_s   = bus.zero_i;
            state_d = S_FETCH;
          end
          3'b010, 3'b011: begin
            pcw_s   = 1'b0;
            state_d = S_ILLEGAL;
          end
          default: begin
            pcw_s   = ~bus.zero_i;
            state_d = S_FETCH;
          end
        endcase
      end
      S_JAL: begin
        srca_s  = 2'b01;
        srcb_s  = 2'b10;
        rw_s    = 1'b1;
        pcw_s   = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR: begin
        // Phase 0 forms rs1+imm into ALUOut; phase 1 links and jumps like JAL.
        if (!phase_q) begin
          srca_s  = 2'b10;
          srcb_s  = 2'b01;
          phase_d = 1'b1;
          state_d = S_JALR;
        end else begin
          srca_s  = 2'b01;
          srcb_s  = 2'b10;
          rw_s    = 1'b1;
          pcw_s   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_LUI: begin
        srcb_s  = 2'b01;
        aluop_s = 2'b11;
        res_s   = 2'b10;
        rw_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_AUIPC: begin
        srca_s  = 2'b01;
        srcb_s  = 2'b01;
        res_s   = 2'b10;
        rw_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        imm_s   = 3'b000;
        state_d = S_ILLEGAL;
      end
      default: begin
        imm_s   = 3'b000;
        state_d = S_ILLEGAL;
      end
    endcase
  end

  // State, JALR phase and one-shot illegal flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      phase_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      illegal_q <= (state_d == S_ILLEGAL) && (state_q != S_ILLEGAL);
    end
  end

  assign bus.ImmSrc_o    = rst_n ? imm_s   : 3'b000;
  assign bus.ALUSrcA_o   = rst_n ? srca_s  : 2'b00;
  assign bus.ALUSrcB_o   = rst_n ? srcb_s  : 2'b00;
  assign bus.ALUOp_o     = rst_n ? aluop_s : 2'b00;
  assign bus.ResultSrc_o = rst_n ? res_s   : 2'b00;
  assign bus.AdrSrc_o    = rst_n & adr_s;
  assign bus.IRWrite_o   = rst_n & irw_s;
  assign bus.PCWrite_o   = rst_n & pcw_s;
  assign bus.RegWrite_o  = rst_n & rw_s;
  assign bus.MemWrite_o  = rst_n & mw_s;
  assign bus.illegal_o   = rst_n & illegal_q;
  assign bus.state_o     = state_q;

`ifdef PERF_CNT_EN
  logic [DATA_WIDTH-1:0] cycle_cnt_q, instret_cnt_q;

  // Free-running cycle count and retirement count on each return to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q   <= {DATA_WIDTH{1'b0}};
      instret_cnt_q <= {DATA_WIDTH{1'b0}};
    end else begin
      cycle_cnt_q <= cycle_cnt_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
        instret_cnt_q <= instret_cnt_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        instret_cnt_q <= instret_cnt_q;
      end
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`endif

endmodule
